// File: rtl/int_bus_arbiter.sv
// Two-master arbiter for the internal register-file bus.
// Round-robin grant, hold timeout preemption, tagged read-data return.
module int_bus_arbiter #(
   parameter int AW      = 8,
   parameter int DW      = 8,
   parameter int RD_LAT  = 1,
   parameter int TIMEOUT = 255
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          m0_req,
   output logic          m0_gnt,
   input  logic [AW-1:0] m0_address,
   input  logic [DW-1:0] m0_wr_data,
   input  logic          m0_write,
   input  logic          m0_read,
   output logic [DW-1:0] m0_rd_data,
   output logic          m0_rd_valid,
   input  logic          m1_req,
   output logic          m1_gnt,
   input  logic [AW-1:0] m1_address,
   input  logic [DW-1:0] m1_wr_data,
   input  logic          m1_write,
   input  logic          m1_read,
   output logic [DW-1:0] m1_rd_data,
   output logic          m1_rd_valid,
   output logic [AW-1:0] int_address,
   output logic [DW-1:0] int_wr_data,
   output logic          int_write,
   output logic          int_read,
   input  logic [DW-1:0] int_rd_data,
   output logic          timeout_evt
);

   localparam int CW =
      (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] HOLD_MAX = CW'(TIMEOUT);
   localparam bit PREEMPT_EN = (TIMEOUT != 0);

   typedef enum logic [1:0] {
      IDLE,
      GRANT0,
      GRANT1,
      DRAIN
   } state_t;

   state_t            state;
   state_t            state_nx;
   state_t            pick;
   state_t            other;
   logic              last_grant;
   logic              last_grant_nx;
   logic [CW-1:0]     hold_cnt;
   logic [CW-1:0]     hold_cnt_nx;
   logic [RD_LAT-1:0] tag_v;
   logic [RD_LAT-1:0] tag_id;
   logic [DW-1:0]     m0_hold;
   logic [DW-1:0]     m1_hold;

   logic granted;
   logic owner;
   logic own_req;
   logic oth_req;
   logic preempt;
   logic active;
   logic pending;
   logic outstanding;

   always_comb begin
      granted = (state == GRANT0) || (state == GRANT1);
      owner   = (state == GRANT1);
      own_req = owner ? m1_req : m0_req;
      oth_req = owner ? m0_req : m1_req;
      preempt = PREEMPT_EN && granted && own_req
                && (hold_cnt >= HOLD_MAX);
      active  = granted && !preempt;
      other   = owner ? GRANT0 : GRANT1;
   end

   // last_grant=1 means master 0 is favoured on the next tie
   always_comb begin
      pick = IDLE;
      if (last_grant) begin
         if (m0_req) begin
            pick = GRANT0;
         end else if (m1_req) begin
            pick = GRANT1;
         end
      end else begin
         if (m1_req) begin
            pick = GRANT1;
         end else if (m0_req) begin
            pick = GRANT0;
         end
      end
   end

   always_comb begin
      int_address = '0;
      int_wr_data = '0;
      int_write   = 1'b0;
      int_read    = 1'b0;
      if (active) begin
         if (owner) begin
            int_address = m1_address;
            int_wr_data = m1_wr_data;
            int_write   = m1_write;
            int_read    = m1_read & ~m1_write;
         end else begin
            int_address = m0_address;
            int_wr_data = m0_wr_data;
            int_write   = m0_write;
            int_read    = m0_read & ~m0_write;
         end
      end
   end

   assign m0_gnt      = (state == GRANT0) && !preempt;
   assign m1_gnt      = (state == GRANT1) && !preempt;
   assign timeout_evt = preempt;

   // Reads still in flight after this cycle's shift; the last stage
   // is returning now and no longer counts.
   always_comb begin
      pending = 1'b0;
      for (int i = 0; i < RD_LAT - 1; i++) begin
         pending = pending | tag_v[i];
      end
      outstanding = pending | int_read;
   end

   always_comb begin
      state_nx      = state;
      last_grant_nx = last_grant;
      hold_cnt_nx   = hold_cnt;
      unique case (state)
         IDLE: begin
            state_nx = pick;
         end
         GRANT0, GRANT1: begin
            if (!own_req) begin
               if (outstanding) begin
                  state_nx = DRAIN;
               end else if (oth_req) begin
                  state_nx = other;
               end else begin
                  state_nx = IDLE;
               end
            end else if (preempt) begin
               state_nx = DRAIN;
            end else if (oth_req && (hold_cnt != '1)) begin
               hold_cnt_nx = hold_cnt + 1'b1;
            end
         end
         DRAIN: begin
            if (!pending) begin
               state_nx = pick;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
      if (state_nx != state) begin
         hold_cnt_nx = '0;
         if (state_nx == GRANT0) begin
            last_grant_nx = 1'b0;
         end else if (state_nx == GRANT1) begin
            last_grant_nx = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         hold_cnt   <= '0;
      end else begin
         state      <= state_nx;
         last_grant <= last_grant_nx;
         hold_cnt   <= hold_cnt_nx;
      end
   end

   // Tag pipeline mirrors the register-file read latency
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tag_v   <= '0;
         tag_id  <= '0;
         m0_hold <= '0;
         m1_hold <= '0;
      end else begin
         tag_v[0]  <= int_read;
         tag_id[0] <= owner;
         for (int i = 1; i < RD_LAT; i++) begin
            tag_v[i]  <= tag_v[i-1];
            tag_id[i] <= tag_id[i-1];
         end
         if (m0_rd_valid) begin
            m0_hold <= int_rd_data;
         end
         if (m1_rd_valid) begin
            m1_hold <= int_rd_data;
         end
      end
   end

   assign m0_rd_valid = tag_v[RD_LAT-1] && !tag_id[RD_LAT-1];
   assign m1_rd_valid = tag_v[RD_LAT-1] && tag_id[RD_LAT-1];
   assign m0_rd_data  = m0_rd_valid ? int_rd_data : m0_hold;
   assign m1_rd_data  = m1_rd_valid ? int_rd_data : m1_hold;

endmodule

// File: tb/tb_int_bus_arbiter.sv
// Bench for int_bus_arbiter: cycle vector table plus read scoreboard.
// Register file modelled as a fixed-latency lookup pipeline.
module tb_int_bus_arbiter;

   localparam int RL = 2;
   localparam int TO = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic m0_req, m0_gnt, m0_write, m0_read, m0_rd_valid;
   logic m1_req, m1_gnt, m1_write, m1_read, m1_rd_valid;
   logic [7:0] m0_address, m0_wr_data, m0_rd_data;
   logic [7:0] m1_address, m1_wr_data, m1_rd_data;
   logic [7:0] int_address, int_wr_data, int_rd_data;
   logic int_write, int_read, timeout_evt;

   always #5 clk = ~clk;

   int_bus_arbiter #(
      .AW(8), .DW(8), .RD_LAT(RL), .TIMEOUT(TO)
   ) dut (
      .clock(clk), .reset(reset),
      .m0_req(m0_req), .m0_gnt(m0_gnt),
      .m0_address(m0_address), .m0_wr_data(m0_wr_data),
      .m0_write(m0_write), .m0_read(m0_read),
      .m0_rd_data(m0_rd_data), .m0_rd_valid(m0_rd_valid),
      .m1_req(m1_req), .m1_gnt(m1_gnt),
      .m1_address(m1_address), .m1_wr_data(m1_wr_data),
      .m1_write(m1_write), .m1_read(m1_read),
      .m1_rd_data(m1_rd_data), .m1_rd_valid(m1_rd_valid),
      .int_address(int_address), .int_wr_data(int_wr_data),
      .int_write(int_write), .int_read(int_read),
      .int_rd_data(int_rd_data), .timeout_evt(timeout_evt)
   );

   function automatic logic [7:0] rf_val(input logic [7:0] a);
      return (a == 8'h21) ? 8'h66 : (a ^ 8'h75);
   endfunction

   logic [7:0] rfp [RL];
   always @(posedge clk) begin
      for (int i = RL - 1; i > 0; i--) rfp[i] <= rfp[i-1];
      rfp[0] <= rf_val(int_address);
   end
   assign int_rd_data = rfp[RL-1];

   int errors = 0;
   int checks = 0;
   logic [8:0] sb [$];
   logic [8:0] sb_e;

   // in: r0 r1 w0 rd0 w1 rd1 ; ex: g0 g1 iw ir te v0 v1
   typedef struct {
      logic       rs;
      logic [5:0] in;
      logic [7:0] a0, d0, a1, d1;
      logic [6:0] ex;
      logic [7:0] ia, id;
   } vec_t;

   vec_t tbl [$];

   function automatic vec_t mk(
      input logic rs, input logic [5:0] in,
      input logic [7:0] a0, d0, a1, d1,
      input logic [6:0] ex, input logic [7:0] ia, id);
      vec_t v;
      v.rs = rs; v.in = in;
      v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
      v.ex = ex; v.ia = ia; v.id = id;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx,
                      input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] got=%h exp=%h", nm, idx, act, exp);
      end
   endtask

   task automatic drive(input logic [5:0] in,
                        input logic [7:0] a0, d0, a1, d1);
      {m0_req, m1_req, m0_write, m0_read, m1_write, m1_read} = in;
      m0_address = a0; m0_wr_data = d0;
      m1_address = a1; m1_wr_data = d1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      drive(6'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic chk_all(input string p, input int k,
                          input logic [6:0] ex,
                          input logic [7:0] ia, id);
      chk({p, "g0"}, k, 8'(m0_gnt), 8'(ex[6]));
      chk({p, "g1"}, k, 8'(m1_gnt), 8'(ex[5]));
      chk({p, "iw"}, k, 8'(int_write), 8'(ex[4]));
      chk({p, "ir"}, k, 8'(int_read), 8'(ex[3]));
      chk({p, "te"}, k, 8'(timeout_evt), 8'(ex[2]));
      chk({p, "v0"}, k, 8'(m0_rd_valid), 8'(ex[1]));
      chk({p, "v1"}, k, 8'(m1_rd_valid), 8'(ex[0]));
      chk({p, "ia"}, k, int_address, ia);
      chk({p, "id"}, k, int_wr_data, id);
   endtask

   // Read-return scoreboard: {master id, data}
   always @(negedge clk) begin
      if (reset && (m0_rd_valid || m1_rd_valid)) begin
         checks++;
         if (m0_rd_valid && m1_rd_valid) begin
            errors++;
            $display("FAIL rd_both got=11 exp=one");
         end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL rd_unexp got=%b%b exp=none",
                     m0_rd_valid, m1_rd_valid);
         end else begin
            sb_e = sb.pop_front();
            if ({m1_rd_valid, m1_rd_valid ? m1_rd_data : m0_rd_data}
                !== sb_e) begin
               errors++;
               $display("FAIL rd_ret got=%b/%h exp=%b/%h",
                        m1_rd_valid,
                        m1_rd_valid ? m1_rd_data : m0_rd_data,
                        sb_e[8], sb_e[7:0]);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      // grant, write passthrough, ignored m1 strobes, read, release
      tbl.push_back(mk(1, 6'b100000, 8'h00, 8'h00, 8'h00, 8'h00, 7'b0000000, 8'h00, 8'h00));
      tbl.push_back(mk(0, 6'b101011, 8'h10, 8'hA5, 8'h33, 8'h44, 7'b1010000, 8'h10, 8'hA5));
      tbl.push_back(mk(0, 6'b100100, 8'h40, 8'h00, 8'h00, 8'h00, 7'b1001000, 8'h40, 8'h00));
      tbl.push_back(mk(0, 6'b100000, 8'h00, 8'h00, 8'h00, 8'h00, 7'b1000000, 8'h00, 8'h00));
      tbl.push_back(mk(0, 6'b000000, 8'h00, 8'h00, 8'h00, 8'h00, 7'b1000010, 8'h00, 8'h00));
      tbl.push_back(mk(0, 6'b000000, 8'h00, 8'h00, 8'h00, 8'h00, 7'b0000000, 8'h00, 8'h00));
      // tie after reset, gapless handoff, next tie
      tbl.push_back(mk(1, 6'b110000, 8'h00, 8'h00, 8'h00, 8'h00, 7'b0000000, 8'h00, 8'h00));
      tbl.push_back(mk(0, 6'b110000, 8'h00, 8'h00, 8'h00, 8'h00, 7'b1000000, 8'h00, 8'h00));
      tbl.push_back(mk(0, 6'b010000, 8'h00, 8'h00, 8'h00, 8'h00, 7'b1000000, 8'h00, 8'h00));
      tbl.push_back(mk(0, 6'b010000, 8'h00, 8'h00, 8'h00, 8'h00, 7'b0100000, 8'h00, 8'h00));
      tbl.push_back(mk(0, 6'b000000, 8'h00, 8'h00, 8'h00, 8'h00, 7'b0100000, 8'h00, 8'h00));
      tbl.push_back(mk(0, 6'b110000, 8'h00, 8'h00, 8'h00, 8'h00, 7'b0000000, 8'h00, 8'h00));
      tbl.push_back(mk(0, 6'b110000, 8'h00, 8'h00, 8'h00, 8'h00, 7'b1000000, 8'h00, 8'h00));
      tbl.push_back(mk(0, 6'b000000, 8'h00, 8'h00, 8'h00, 8'h00, 7'b1000000, 8'h00, 8'h00));
      tbl.push_back(mk(0, 6'b000000, 8'h00, 8'h00, 8'h00, 8'h00, 7'b0000000, 8'h00, 8'h00));
      // m1 back-to-back reads, then write beats read
      tbl.push_back(mk(0, 6'b010000, 8'h00, 8'h00, 8'h00, 8'h00, 7'b0000000, 8'h00, 8'h00));
      tbl.push_back(mk(0, 6'b010001, 8'h00, 8'h00, 8'h20, 8'h00, 7'b0101000, 8'h20, 8'h00));
      tbl.push_back(mk(0, 6'b010001, 8'h00, 8'h00, 8'h21, 8'h00, 7'b0101000, 8'h21, 8'h00));
      tbl.push_back(mk(0, 6'b010011, 8'h00, 8'h00, 8'h22, 8'h77, 7'b0110001, 8'h22, 8'h77));
      tbl.push_back(mk(0, 6'b010000, 8'h00, 8'h00, 8'h00, 8'h00, 7'b0100001, 8'h00, 8'h00));
      tbl.push_back(mk(0, 6'b000000, 8'h00, 8'h00, 8'h00, 8'h00, 7'b0100000, 8'h00, 8'h00));
      // m0 read then release while m1 waits: drain
      tbl.push_back(mk(0, 6'b100000, 8'h00, 8'h00, 8'h00, 8'h00, 7'b0000000, 8'h00, 8'h00));
      tbl.push_back(mk(0, 6'b110100, 8'h50, 8'h00, 8'h00, 8'h00, 7'b1001000, 8'h50, 8'h00));
      tbl.push_back(mk(0, 6'b010000, 8'h00, 8'h00, 8'h00, 8'h00, 7'b1000000, 8'h00, 8'h00));
      tbl.push_back(mk(0, 6'b010000, 8'h00, 8'h00, 8'h00, 8'h00, 7'b0000010, 8'h00, 8'h00));
      tbl.push_back(mk(0, 6'b010000, 8'h00, 8'h00, 8'h00, 8'h00, 7'b0100000, 8'h00, 8'h00));
      tbl.push_back(mk(0, 6'b000000, 8'h00, 8'h00, 8'h00, 8'h00, 7'b0100000, 8'h00, 8'h00));
      tbl.push_back(mk(0, 6'b000000, 8'h00, 8'h00, 8'h00, 8'h00, 7'b0000000, 8'h00, 8'h00));
      // hold timeout with a read in flight, later regrant of m0
      tbl.push_back(mk(0, 6'b110000, 8'h00, 8'h00, 8'h00, 8'h00, 7'b0000000, 8'h00, 8'h00));
      tbl.push_back(mk(0, 6'b110000, 8'h00, 8'h00, 8'h00, 8'h00, 7'b1000000, 8'h00, 8'h00));
      tbl.push_back(mk(0, 6'b110000, 8'h00, 8'h00, 8'h00, 8'h00, 7'b1000000, 8'h00, 8'h00));
      tbl.push_back(mk(0, 6'b110000, 8'h00, 8'h00, 8'h00, 8'h00, 7'b1000000, 8'h00, 8'h00));
      tbl.push_back(mk(0, 6'b110100, 8'h60, 8'h00, 8'h00, 8'h00, 7'b1001000, 8'h60, 8'h00));
      tbl.push_back(mk(0, 6'b110100, 8'h61, 8'h00, 8'h00, 8'h00, 7'b0000100, 8'h00, 8'h00));
      tbl.push_back(mk(0, 6'b110000, 8'h00, 8'h00, 8'h00, 8'h00, 7'b0000010, 8'h00, 8'h00));
      tbl.push_back(mk(0, 6'b110000, 8'h00, 8'h00, 8'h00, 8'h00, 7'b0100000, 8'h00, 8'h00));
      tbl.push_back(mk(0, 6'b100000, 8'h00, 8'h00, 8'h00, 8'h00, 7'b0100000, 8'h00, 8'h00));
      tbl.push_back(mk(0, 6'b100000, 8'h00, 8'h00, 8'h00, 8'h00, 7'b1000000, 8'h00, 8'h00));
      tbl.push_back(mk(0, 6'b000000, 8'h00, 8'h00, 8'h00, 8'h00, 7'b1000000, 8'h00, 8'h00));
      tbl.push_back(mk(0, 6'b000000, 8'h00, 8'h00, 8'h00, 8'h00, 7'b0000000, 8'h00, 8'h00));

      // outputs held quiet in reset despite active inputs
      drive(6'b101011, 8'hFF, 8'hFF, 8'hEE, 8'hEE);
      @(negedge clk);
      chk_all("rst_", 0, 7'b0, 8'h00, 8'h00);
      chk("rst_rd0", 0, m0_rd_data, 8'h00);
      chk("rst_rd1", 0, m1_rd_data, 8'h00);

      for (int k = 0; k < tbl.size(); k++) begin
         if (tbl[k].rs) do_reset();
         drive(tbl[k].in, tbl[k].a0, tbl[k].d0,
               tbl[k].a1, tbl[k].d1);
         if (tbl[k].ex[3])
            sb.push_back({tbl[k].ex[5], rf_val(tbl[k].ia)});
         @(negedge clk);
         chk_all("v_", k, tbl[k].ex, tbl[k].ia, tbl[k].id);
         @(posedge clk);
         #1;
      end

      // asynchronous reset during GRANT1 with a read in flight
      drive(6'b010000, 8'h00, 8'h00, 8'h00, 8'h00);
      @(posedge clk);
      #1;
      drive(6'b010001, 8'h00, 8'h00, 8'h70, 8'h00);
      @(negedge clk);
      chk("ar_g1", 0, 8'(m1_gnt), 8'h01);
      chk("ar_ir", 0, 8'(int_read), 8'h01);
      @(posedge clk);
      #1;
      chk("ar_pre", 0, 8'(m1_gnt), 8'h01);
      reset = 1'b0;
      #1;
      chk("ar_g0", 1, 8'(m0_gnt), 8'h00);
      chk("ar_g1", 1, 8'(m1_gnt), 8'h00);
      chk("ar_v0", 1, 8'(m0_rd_valid), 8'h00);
      chk("ar_v1", 1, 8'(m1_rd_valid), 8'h00);
      drive(6'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      for (int k = 0; k < RL + 2; k++) begin
         @(negedge clk);
         chk("ar_post_v0", k, 8'(m0_rd_valid), 8'h00);
         chk("ar_post_v1", k, 8'(m1_rd_valid), 8'h00);
         @(posedge clk);
         #1;
      end
      drive(6'b110000, 8'h00, 8'h00, 8'h00, 8'h00);
      @(negedge clk);
      chk("ar_tie_g0", 0, 8'(m0_gnt), 8'h00);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("ar_tie_g0", 1, 8'(m0_gnt), 8'h01);
      chk("ar_tie_g1", 1, 8'(m1_gnt), 8'h00);
      @(posedge clk);
      #1;
      drive(6'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      @(posedge clk);
      #1;
      chk("sb_left", 0, 8'(sb.size()), 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
